// File: rtl/fifo_rd_drain.sv
// Read-domain consumer for the asynchronous FIFO. It pops words, hides the FIFO's
// one-cycle read latency behind a 2-entry buffer, counts words and checks the sequence.
module fifo_rd_drain #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_W      = 32,
    parameter bit SEQ_CHECK  = 1'b1
) (
    input  logic                  r_clk,
    input  logic                  r_rst,
    input  logic                  fifo_empty,
    output logic                  r_en,
    input  logic [DATA_WIDTH-1:0] read_data,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    input  logic                  seq_clr,
    output logic [CNT_W-1:0]      word_cnt,
    output logic                  seq_err,
    output logic [DATA_WIDTH-1:0] err_expect,
    output logic [DATA_WIDTH-1:0] err_data
);

    logic [1:0]            occ;
    logic                  inflight;
    logic [DATA_WIDTH-1:0] head;
    logic [DATA_WIDTH-1:0] tail;
    logic                  pop;
    logic [2:0]            fill;

    assign pop     = m_valid & m_ready;
    assign m_valid = (occ != 2'd0);
    assign m_data  = head;

    // Words already committed (buffered or in flight) after this cycle's pop; a new
    // pop is only safe while that leaves room for one more word in the buffer.
    assign fill = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    assign r_en = !r_rst && !fifo_empty && (fill <= 3'd1);

    always_ff @(posedge r_clk or posedge r_rst) begin
        if (r_rst) begin
            inflight <= 1'b0;
        end else begin
            inflight <= r_en;
        end
    end

    always_ff @(posedge r_clk or posedge r_rst) begin
        if (r_rst) begin
            occ  <= 2'd0;
            head <= '0;
            tail <= '0;
        end else begin
            case ({inflight, pop})
                2'b10: begin
                    if (occ == 2'd0) begin
                        head <= read_data;
                    end else begin
                        tail <= read_data;
                    end
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    head <= tail;
                    occ  <= occ - 2'd1;
                end
                2'b11: begin
                    // Simultaneous write and pop: occupancy unchanged, order kept.
                    if (occ == 2'd2) begin
                        head <= tail;
                        tail <= read_data;
                    end else begin
                        head <= read_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge r_clk or posedge r_rst) begin
        if (r_rst) begin
            word_cnt <= '0;
        end else if (pop) begin
            word_cnt <= word_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    generate
        if (SEQ_CHECK) begin : g_seq
            logic [DATA_WIDTH-1:0] expected;

            // A clear coinciding with a pop wins, so expected restarts at 0.
            always_ff @(posedge r_clk or posedge r_rst) begin
                if (r_rst) begin
                    expected   <= '0;
                    seq_err    <= 1'b0;
                    err_expect <= '0;
                    err_data   <= '0;
                end else if (seq_clr) begin
                    expected   <= '0;
                    seq_err    <= 1'b0;
                    err_expect <= '0;
                    err_data   <= '0;
                end else if (pop) begin
                    if ((m_data != expected) && !seq_err) begin
                        seq_err    <= 1'b1;
                        err_expect <= expected;
                        err_data   <= m_data;
                    end
                    expected <= m_data + {{(DATA_WIDTH-1){1'b0}}, 1'b1};
                end
            end
        end else begin : g_no_seq
            assign seq_err    = 1'b0;
            assign err_expect = '0;
            assign err_data   = '0;
        end
    endgenerate

endmodule

// File: doc/fifo_rd_drain.md
Name: fifo_rd_drain

Overview:
- Read-domain consumer for the team's asynchronous FIFO.
- Pops words through the FIFO's r_en / read_data / fifo_empty interface, hides the FIFO's one-cycle read latency behind a 2-entry output buffer, and presents a valid/ready stream downstream.
- Counts every delivered word and optionally checks that words form an incrementing sequence, which is the pattern our FIFO benches write.

Parameters:
- DATA_WIDTH, 32, width of FIFO words and of m_data.
- CNT_W, 32, width of the delivered-word counter.
- SEQ_CHECK, 1, 1 enables the incrementing-sequence checker; 0 holds seq_err, err_expect and err_data at 0.

Ports:
- r_clk  in  1  read-domain clock; the only clock.
- r_rst  in  1  asynchronous, active-high reset.
- fifo_empty  in  1  FIFO empty flag, synchronous to r_clk.
- r_en  out  1  FIFO pop request.
- read_data  in  DATA_WIDTH  FIFO output word, valid the cycle after a pop.
- m_data  out  DATA_WIDTH  stream data (buffer head).
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready from the downstream sink.
- seq_clr  in  1  synchronous: reset the checker's expected value to 0 and clear the error fields.
- word_cnt  out  CNT_W  number of words delivered on the stream.
- seq_err  out  1  sticky sequence-mismatch flag.
- err_expect  out  DATA_WIDTH  expected value at the first mismatch.
- err_data  out  DATA_WIDTH  received value at the first mismatch.

Behaviour:
- Reset (r_rst=1, asynchronous):
  - occ=0, inflight=0, m_valid=0, m_data=0, word_cnt=0, seq_err=0, err_expect=0, err_data=0, expected=0.
  - r_en=0 for as long as r_rst is high.
- pop = m_valid & m_ready.
- r_en (combinational) = !r_rst & !fifo_empty & (occ + inflight - pop <= 1).
  - r_en is never asserted while fifo_empty=1.
  - r_en depends combinationally on m_ready.
- inflight register: set to r_en each cycle. When inflight=1, read_data is written into the buffer at that clock edge.
- Buffer:
  - 2-entry FIFO; occ ranges 0..2.
  - Write and pop in the same cycle leave occ unchanged and preserve word order.
  - occ never exceeds 2. Overflow is impossible by construction; the bench asserts it.
- Outputs: m_valid = (occ != 0). m_data = head entry.
  - While m_valid=1 and m_ready=0, m_data must stay stable.
- Latency: r_en high in cycle N; read_data valid in N+1; m_valid high in N+2 (when the buffer was empty).
- Throughput: sustained 1 word/cycle when fifo_empty=0 and m_ready=1 continuously (steady state occ=1, inflight=1).
- Backpressure: with m_ready=0, at most 2 words are popped, after which r_en stays 0. No data is lost.
- word_cnt: increments by 1 on every pop and wraps modulo 2^CNT_W. seq_clr does not clear it.
- Sequence checker (SEQ_CHECK=1), evaluated on each pop:
  - If m_data != expected and seq_err=0: set seq_err, capture err_expect=expected and err_data=m_data.
  - Always: expected <= m_data + 1 (mod 2^DATA_WIDTH), so the checker resyncs after a mismatch.
  - Only the first mismatch is captured. seq_err stays set until seq_clr or reset.
- seq_clr:
  - Sets expected=0 and clears seq_err, err_expect and err_data.
  - If it coincides with a pop, the clear wins; expected becomes 0, not m_data+1.
- fifo_empty asserting while inflight=1: the in-flight word is still captured; no further r_en is issued.
- Reset mid-transfer: buffered and in-flight words are discarded. The FIFO is reset together with this block by system convention.

Test Plan:
- Reset then idle: r_rst pulse with fifo_empty=1 -> r_en, m_valid, word_cnt, seq_err all 0; r_en stays 0 for 20 cycles.
- Streaming: FIFO preloaded with 0..1123, m_ready=1 -> r_en continuous, m_valid first high 2 cycles after the first r_en; m_data 0..1123 one per cycle; word_cnt=1124; seq_err=0.
- Backpressure: m_ready=0 with FIFO holding 0..99 -> exactly 2 r_en pulses, occ=2, m_data=0 stable. Releasing m_ready -> 0..99 in order, word_cnt=100.
- Random m_ready (50%) during concurrent FIFO writes of 0..923 -> all 924 words delivered in order; no r_en while fifo_empty=1; occ <= 2 always.
- Sequence error: FIFO contents 0,1,2,7,8 -> seq_err=1, err_expect=3, err_data=7, no further error on 8. Then seq_clr followed by words 0,1 -> seq_err=0 stays 0.
- Reset mid-stream: assert r_rst with occ=2 and inflight=1 -> m_valid=0 and word_cnt=0 immediately (asynchronous); after release, normal streaming resumes from the next FIFO word.
